sgdmac_write_engine: RTL

//  Downstream stage of the scatter-gather DMA read engine: drains 32-bit words from the shared data FIFO
//  and writes them to memory as AXI3 INCR bursts (max 16 beats / 64 B). One command is one descriptor:
//  {dest_addr[31:0], byte_count[15:0]}. Per burst: AW, then W beats, then wait for B before the next AW.

---
 rtl/sgdmac_pkg.sv | 27 ++
 rtl/sgdmac_write_engine.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sgdmac_pkg.sv
// Shared types, AXI constants and burst helpers for the scatter-gather DMA engines.
package sgdmac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AW,
        W,
        B
    } state_t;

    localparam int         MAX_BURST_BYTES = 64;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

    // Burst length (beats - 1) for the next burst given the bytes still to move.
    function automatic logic [3:0] calc_len(input logic [15:0] remaining);
        logic [3:0] words;
        words = remaining[5:2];
        if (remaining >= 16'(MAX_BURST_BYTES)) begin
            calc_len = 4'hF;
        end else begin
            calc_len = words - 4'd1;
        end
    endfunction

endpackage

// File: rtl/sgdmac_write_engine.sv
// Write side of the scatter-gather DMA: drains the data FIFO into memory
// as AXI3 INCR bursts of up to 16 words, one burst outstanding at a time.
module sgdmac_write_engine
    import sgdmac_pkg::*;
#(
    parameter int         FIFO_DEPTH = 64,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [47:0]                   cmd_i,
    output logic                          done_o,
    output logic                          err_o,
    input  logic                          fifo_empty_i,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_i,
    input  logic [31:0]                   fifo_rdata_i,
    output logic                          fifo_rden_o,
    output logic [3:0]                    awid_o,
    output logic [31:0]                   awaddr_o,
    output logic [3:0]                    awlen_o,
    output logic [2:0]                    awsize_o,
    output logic [1:0]                    awburst_o,
    output logic                          awvalid_o,
    input  logic                          awready_i,
    output logic [3:0]                    wid_o,
    output logic [31:0]                   wdata_o,
    output logic [3:0]                    wstrb_o,
    output logic                          wlast_o,
    output logic                          wvalid_o,
    input  logic                          wready_i,
    input  logic [3:0]                    bid_i,
    input  logic [1:0]                    bresp_i,
    input  logic                          bvalid_i,
    output logic                          bready_o
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic [3:0]  len_q, len_d;
    logic        err_q, err_d;

    logic [3:0]  next_len;
    logic [4:0]  burst_words;
    logic        fifo_ready;
    logic        beat_fire;

    logic unused_ok;
    assign unused_ok = ^{bid_i, cmd_i[1:0]};

    assign next_len    = calc_len(remaining_q);
    assign burst_words = {1'b0, next_len} + 5'd1;
    // Holding AW until the whole burst is buffered keeps W from ever stalling.
    assign fifo_ready  = 32'(fifo_cnt_i) >= 32'(burst_words);

    assign awid_o    = AXI_ID;
    assign awaddr_o  = addr_q;
    assign awlen_o   = next_len;
    assign awsize_o  = AXI_SIZE_4B;
    assign awburst_o = AXI_BURST_INCR;
    assign wid_o     = AXI_ID;
    assign wdata_o   = fifo_rdata_i;
    assign wstrb_o   = 4'hF;
    assign err_o     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        err_d       = err_q;
        done_o      = 1'b0;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        wlast_o     = 1'b0;
        fifo_rden_o = 1'b0;
        bready_o    = 1'b0;
        beat_fire   = 1'b0;

        unique case (state_q)
            IDLE: begin
                done_o = 1'b1;
                if (start_i) begin
                    addr_d      = cmd_i[47:16];
                    // Word granularity: the low two count bits never reach the datapath.
                    remaining_d = {cmd_i[15:2], 2'b00};
                    err_d       = 1'b0;
                    if (cmd_i[15:2] != '0) begin
                        state_d = AW;
                    end
                end
            end
            AW: begin
                awvalid_o = fifo_ready;
                if (fifo_ready && awready_i) begin
                    len_d      = next_len;
                    beat_cnt_d = '0;
                    addr_d     = addr_q + 32'(MAX_BURST_BYTES);
                    if (remaining_q < 16'(MAX_BURST_BYTES)) begin
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - 16'(MAX_BURST_BYTES);
                    end
                    state_d = W;
                end
            end
            W: begin
                wvalid_o    = !fifo_empty_i;
                wlast_o     = (beat_cnt_q == len_q);
                beat_fire   = !fifo_empty_i && wready_i;
                fifo_rden_o = beat_fire;
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (beat_cnt_q == len_q) begin
                        state_d = B;
                    end
                end
            end
            B: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    if (bresp_i != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    state_d = (remaining_q == '0) ? IDLE : AW;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
